irq_ctrl: RTL

//  Parametrised, memory-mapped external interrupt controller that folds the core's fixed per-peripheral

---
 rtl/irq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped external interrupt controller with per-source edge/level
// capture, priority/threshold arbitration and claim/complete in-service tracking.
module irq_ctrl #(
  parameter int NUM_SRC     = 16,
  parameter int PRIO_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_SRC-1:0]    i_src,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_wr_strobe,
  output logic [31:0]           o_rd_data,
  output logic                  o_irq
);

  localparam logic [ADDR_WIDTH-1:0] A_PENDING   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_ENABLE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE_MODE = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_THRESHOLD = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_CLAIM     = ADDR_WIDTH'(4);
  localparam int                    A_PRIO_BASE = 8;

  logic [NUM_SRC-1:0]    r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0]    r_synced_q;
  logic [NUM_SRC-1:0]    r_pending;
  logic [NUM_SRC-1:0]    r_enable;
  logic [NUM_SRC-1:0]    r_edge_mode;
  logic [NUM_SRC-1:0]    r_in_service;
  logic [PRIO_WIDTH-1:0] r_threshold;
  logic [PRIO_WIDTH-1:0] r_prio [NUM_SRC];
  logic                  r_irq;

  logic [NUM_SRC-1:0]    w_synced;
  logic [NUM_SRC-1:0]    w_rise;
  logic [NUM_SRC-1:0]    w_eligible;
  logic [NUM_SRC-1:0]    w_claim_mask;
  logic [NUM_SRC-1:0]    w_complete_mask;
  logic [NUM_SRC-1:0]    w_pending_next;
  logic [5:0]            w_best_id;
  logic [PRIO_WIDTH-1:0] w_best_prio;
  logic [31:0]           w_byte_mask;
  logic                  w_claim;
  logic                  w_complete;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_synced    = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_synced & ~r_synced_q;
  assign w_byte_mask = {{8{i_wr_strobe[3]}}, {8{i_wr_strobe[2]}},
                        {8{i_wr_strobe[1]}}, {8{i_wr_strobe[0]}}};
  // A CLAIM read that coincides with a CLAIM write is treated as a complete only.
  assign w_claim     = i_rd_en & (i_addr == A_CLAIM) & ~i_wr_en & (w_best_id != 6'd0);
  assign w_complete  = i_wr_en & (i_addr == A_CLAIM) & i_wr_strobe[0];
  assign o_irq       = r_irq;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_synced_q <= '0;
    end else begin
      r_sync[0] <= i_src;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_synced_q <= w_synced;
    end
  end

  // Ties resolve to the lowest ID because only a strictly higher priority replaces the winner.
  always_comb begin
    w_eligible  = '0;
    w_best_id   = '0;
    w_best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_eligible[i] = r_pending[i] & r_enable[i] & ~r_in_service[i] & (r_prio[i] > r_threshold);
      if (w_eligible[i] && (r_prio[i] > w_best_prio)) begin
        w_best_prio = r_prio[i];
        w_best_id   = 6'(i + 1);
      end
    end
  end

  always_comb begin
    w_claim_mask    = '0;
    w_complete_mask = '0;
    w_pending_next  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim_mask[i]    = w_claim & (w_best_id == 6'(i + 1));
      w_complete_mask[i] = w_complete & (i_wr_data[5:0] == 6'(i + 1));
      if (r_edge_mode[i])
        w_pending_next[i] = w_claim_mask[i] ? w_rise[i] : (r_pending[i] | w_rise[i]);
      else
        w_pending_next[i] = w_synced[i] & ~r_in_service[i] & ~w_claim_mask[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_enable     <= '0;
      r_edge_mode  <= '0;
      r_threshold  <= '0;
      r_irq        <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
    end else begin
      r_pending    <= w_pending_next;
      r_in_service <= (r_in_service | w_claim_mask) & ~w_complete_mask;
      r_irq        <= (w_best_id != 6'd0);
      if (i_wr_en) begin
        if (i_addr == A_ENABLE)
          r_enable <= NUM_SRC'(merge_bytes(32'(r_enable), i_wr_data, w_byte_mask));
        if (i_addr == A_EDGE_MODE)
          r_edge_mode <= NUM_SRC'(merge_bytes(32'(r_edge_mode), i_wr_data, w_byte_mask));
        if (i_addr == A_THRESHOLD)
          r_threshold <= PRIO_WIDTH'(merge_bytes(32'(r_threshold), i_wr_data, w_byte_mask));
        for (int i = 0; i < NUM_SRC; i++)
          if (i_addr == ADDR_WIDTH'(A_PRIO_BASE + i))
            r_prio[i] <= PRIO_WIDTH'(merge_bytes(32'(r_prio[i]), i_wr_data, w_byte_mask));
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_en) begin
      case (i_addr)
        A_PENDING:   o_rd_data = 32'(r_pending);
        A_ENABLE:    o_rd_data = 32'(r_enable);
        A_EDGE_MODE: o_rd_data = 32'(r_edge_mode);
        A_THRESHOLD: o_rd_data = 32'(r_threshold);
        A_CLAIM:     o_rd_data = 32'(w_best_id);
        default: begin
          for (int i = 0; i < NUM_SRC; i++)
            if (i_addr == ADDR_WIDTH'(A_PRIO_BASE + i)) o_rd_data = 32'(r_prio[i]);
        end
      endcase
    end
  end

endmodule
